// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the round-robin FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  localparam int STAT_W = 8;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the write arbiter.
// The master modport is the arbiter; slave is the surrounding environment.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_data;

  modport master (
    input  req, data_in, fifo_full,
    output gnt, ack, fifo_wr_en, fifo_data
  );

  modport slave (
    output req, data_in, fifo_full,
    input  gnt, ack, fifo_wr_en, fifo_data
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at index >= ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  // Scan from ptr upward; the first hit wins and masks later candidates.
  always_comb begin
    logic [PW-1:0] idx;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// Optional per-requester tenure counters under FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef FIFO_ARB_STATS_EN
  output logic [NREQ*STAT_W-1:0]    tenure_cnt,
`endif
  fifo_wr_arbiter_if.master         bus
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);

  arb_state_t      state_r, state_n;
  logic [NREQ-1:0] gnt_r, gnt_n;
  logic [PW-1:0]   rr_ptr_r, rr_ptr_n;
  logic [CW-1:0]   beat_cnt_r, beat_cnt_n;

  logic [NREQ-1:0] pick_oh_s;
  logic            pick_valid_s;
  logic [NREQ-1:0] ack_s;
  logic            beat_s;
  logic            owner_req_s;
  logic [PW-1:0]   owner_s;
  logic [WIDTH-1:0] data_s;

  function automatic logic [PW-1:0] onehot_idx(input logic [NREQ-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) begin
        idx = idx | PW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (rr_ptr_r),
    .winner (pick_oh_s),
    .valid  (pick_valid_s)
  );

  // Beat acceptance and owner data select, all from the registered grant.
  always_comb begin
    ack_s       = gnt_r & bus.req & {NREQ{~bus.fifo_full}};
    beat_s      = |ack_s;
    owner_req_s = |(gnt_r & bus.req);
    owner_s     = onehot_idx(gnt_r);
    data_s      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_r[i]) begin
        data_s = data_s | bus.data_in[i*WIDTH +: WIDTH];
      end else begin
        data_s = data_s;
      end
    end
  end

  assign bus.gnt        = gnt_r;
  assign bus.ack        = ack_s;
  assign bus.fifo_wr_en = beat_s;
  assign bus.fifo_data  = data_s;

  // Next-state logic: arbitrate in IDLE, count beats and close tenures in OWN.
  always_comb begin
    state_n    = state_r;
    gnt_n      = gnt_r;
    rr_ptr_n   = rr_ptr_r;
    beat_cnt_n = beat_cnt_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_valid_s) begin
          gnt_n      = pick_oh_s;
          beat_cnt_n = '0;
          state_n    = ARB_OWN;
        end else begin
          state_n = ARB_IDLE;
        end
      end
      ARB_OWN: begin
        if (!owner_req_s || (beat_s && beat_cnt_r == CW'(BURST - 1))) begin
          // A dropped request forfeits the rest of the tenure.
          gnt_n      = '0;
          state_n    = ARB_IDLE;
          rr_ptr_n   = (owner_s == PW'(NREQ - 1)) ? '0 : owner_s + PW'(1);
          beat_cnt_n = beat_s ? beat_cnt_r + CW'(1) : beat_cnt_r;
        end else if (beat_s) begin
          beat_cnt_n = beat_cnt_r + CW'(1);
        end else begin
          beat_cnt_n = beat_cnt_r;
        end
      end
      default: begin
        state_n = ARB_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ARB_IDLE;
      gnt_r      <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
    end else begin
      state_r    <= state_n;
      gnt_r      <= gnt_n;
      rr_ptr_r   <= rr_ptr_n;
      beat_cnt_r <= beat_cnt_n;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] stat_r [NREQ];

  // Saturating tenure counters, bumped on each entry to ARB_OWN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        stat_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (state_r == ARB_IDLE && pick_oh_s[i] && stat_r[i] != {STAT_W{1'b1}}) begin
          stat_r[i] <= stat_r[i] + STAT_W'(1);
        end else begin
          stat_r[i] <= stat_r[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign tenure_cnt[g*STAT_W +: STAT_W] = stat_r[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (NREQ=4, WIDTH=8, BURST=4).
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

`ifdef FIFO_ARB_STATS_EN
  logic [4*STAT_W-1:0] tenure_cnt;
`endif

  fifo_wr_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

  fifo_wr_arbiter #(
    .NREQ  (4),
    .WIDTH (8),
    .BURST (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef FIFO_ARB_STATS_EN
    .tenure_cnt (tenure_cnt),
`endif
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       wr;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] req, input logic full, input logic [3:0] gnt,
                     input logic [3:0] ack, input logic wr, input logic [7:0] data);
    vec_t v;
    v.req = req; v.full = full; v.gnt = gnt; v.ack = ack; v.wr = wr; v.data = data;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] gnt, input logic [3:0] ack,
                            input logic wr, input logic [7:0] data);
    check({tag, ".gnt"},  32'(bus.gnt),        32'(gnt));
    check({tag, ".ack"},  32'(bus.ack),        32'(ack));
    check({tag, ".wr"},   32'(bus.fifo_wr_en), 32'(wr));
    check({tag, ".data"}, 32'(bus.fifo_data),  32'(data));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.fifo_full = 1'b0;
    bus.data_in = {8'h44, 8'h33, 8'h22, 8'h11};

    // Round robin with all active: 0,1,2,3,0, four beats then one bubble.
    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < 4; b++) begin
        add(4'b1111, 1'b0, 4'(1 << t), 4'(1 << t), 1'b1, 8'(8'h11 * (t + 1)));
      end
      add(4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
    end
    add(4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h11);
    add(4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'h11);
    add(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
    // Full stall: requester 2, full for 3 cycles after beat 1.
    add(4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
    add(4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h33);
    for (int i = 0; i < 3; i++) add(4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b0, 8'h33);
    for (int i = 0; i < 3; i++) add(4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h33);
    add(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
    // Early release: requester 1 (won via wrap from ptr 3) drops after 2 beats.
    add(4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
    add(4'b1010, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h22);
    add(4'b1010, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h22);
    add(4'b1000, 1'b0, 4'b0010, 4'b0000, 1'b0, 8'h22);
    add(4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
    add(4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'h44);
    add(4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b0, 8'h44);
    // Park rr_ptr at 3 via a zero-beat tenure by requester 2, then req=1001.
    add(4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
    add(4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 8'h33);
    add(4'b1001, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) add(4'b1001, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'h44);
    add(4'b1001, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
    add(4'b1001, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h11);

    // Reset state with all requesting.
    @(negedge clk);
    #1;
    check_outs("reset", 4'b0000, 4'b0000, 1'b0, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.req = vecs[i].req;
      bus.fifo_full = vecs[i].full;
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].ack, vecs[i].wr, vecs[i].data);
    end

    // Asynchronous reset mid-tenure clears the grant without waiting for an edge.
    @(negedge clk);
    #1;
    check_outs("pre_arst", 4'b0001, 4'b0001, 1'b1, 8'h11);
    rst = 1'b1;
    #1;
    check_outs("arst_now", 4'b0000, 4'b0000, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    check_outs("arst_hold", 4'b0000, 4'b0000, 1'b0, 8'h00);
    rst = 1'b0;
    bus.req = 4'b0001;
    @(negedge clk);
    #1;
    check_outs("post_arst", 4'b0001, 4'b0001, 1'b1, 8'h11);

`ifdef FIFO_ARB_STATS_EN
    // Requester 0 alone: one tenure every 5 cycles, well past 255 tenures.
    repeat (1500) @(negedge clk);
    #1;
    check("stat0_sat", 32'(tenure_cnt[7:0]), 32'd255);
    check("stat_other", 32'(tenure_cnt[31:8]), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `simple_fifo`-style write interface among NREQ requesters. It grants one requester a tenure of up to BURST beats, stalls cleanly on FIFO full, and rotates priority after every tenure. It sits directly in front of the FIFO's `wr_en`/`data_in`/`full` pins.

## Interface
- `NREQ`, 4, number of requesters (≥2)
- `WIDTH`, 8, data width, equal to the FIFO WIDTH
- `BURST`, 4, maximum accepted beats per tenure (≥1)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  NREQ  per-requester write request; requester i holds its data stable while `req[i]` is high
- `data_in`  in  NREQ*WIDTH  flattened data; requester i occupies bits [i*WIDTH +: WIDTH]
- `gnt`  out  NREQ  registered one-hot grant (all-zero when idle)
- `ack`  out  NREQ  per-requester beat accepted this cycle = `gnt[i] & req[i] & !fifo_full`
- `fifo_full`  in  1  FIFO full flag
- `fifo_wr_en`  out  1  FIFO write enable = OR of `ack`
- `fifo_data`  out  WIDTH  data of the current owner; 0 when `gnt` is 0

## Operation
- State machine ARB_IDLE / ARB_OWN. Registers: `state`, `gnt`, `rr_ptr` ($clog2(NREQ) bits), `beat_cnt` ($clog2(BURST+1) bits).
- Reset values: state=ARB_IDLE, gnt=0, rr_ptr=0, beat_cnt=0. Outputs therefore reset to ack=0, fifo_wr_en=0, fifo_data=0.
- ARB_IDLE:
  - if any `req` is high, the winner is the first requester at index ≥ rr_ptr, wrapping modulo NREQ.
  - next edge: gnt ← onehot(winner), beat_cnt ← 0, state ← ARB_OWN.
  - if no request, stay idle.
- ARB_OWN, each cycle:
  - a beat transfers when `ack[owner]` is high; beat_cnt then increments.
  - fifo_full high → no beat and no count. The tenure is held, with no timeout.
  - Tenure ends at the edge where either (a) the accepted beat brings beat_cnt to BURST, or (b) `req[owner]` is low.
  - On end: gnt ← 0, rr_ptr ← (owner+1) mod NREQ, state ← ARB_IDLE.
- Requests from non-owners are ignored during a tenure. There is no preemption.
- A requester that drops `req` mid-tenure forfeits the remainder of its tenure. Beats already accepted stand.

## Timing
- Request to first possible write: 1 cycle. `req` sampled in IDLE → `gnt` high next cycle → `fifo_wr_en` the same cycle if not full.
- `ack`, `fifo_wr_en` and `fifo_data` are combinational from the registered `gnt`, `req`, `data_in` and `fifo_full`. The FIFO captures on the same edge.
- Every tenure is followed by exactly one IDLE arbitration cycle (bubble). Peak throughput is BURST beats per BURST+1 cycles.
- Rotation:
  - rr_ptr wraps from NREQ-1 to 0.
  - With all requesters active, the grant order is 0,1,…,NREQ-1,0.
- Asynchronous reset mid-tenure clears gnt immediately. No FIFO write occurs in that cycle or after until re-arbitration.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - adds output `tenure_cnt` (NREQ*8): per-requester 8-bit tenure counters.
  - a counter increments on entry to ARB_OWN for that requester and saturates at 255.
  - counters reset to 0.
- `FIFO_ARB_STATS_EN` undefined: the port and counters are absent. Arbitration behaviour is identical.

## Structure
- Package `fifo_arb_pkg`: state enum `arb_state_t` {ARB_IDLE, ARB_OWN}; constant for the stats counter width (8).
- Sub-module `rr_pick`: combinational. Inputs are the `req` vector and `rr_ptr`; output is the one-hot winner plus a valid flag. It is instantiated once.
- The top holds the FSM, the counters and the output muxing.

## Test plan
- Reset checks:
  - assert rst with req=4'b1111 → gnt=0, fifo_wr_en=0.
  - release rst → gnt=4'b0001 one cycle later.
- Round-robin: req=4'b1111 held, BURST=4, fifo_full=0 → tenures granted 0,1,2,3,0 in order. Each tenure has 4 writes followed by a 1-cycle gap.
- Full stall: requester 2 owns, fifo_full high for 3 cycles after beat 1 → no writes while full, beat_cnt frozen at 1, tenure resumes and ends after 4 total beats.
- Early release: requester 1 owns and drops req after 2 beats → gnt clears next edge, rr_ptr=2, requester 3 (only other requester) wins next.
- Wrap: rr_ptr=3, req=4'b1001 → requester 3 is granted first, then requester 0.
- Stats (`FIFO_ARB_STATS_EN`): 300 tenures by requester 0 → tenure_cnt[7:0]=255, saturated; other fields 0.
